// File: rtl/ntt_mlkem_masked_share_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_defines_pkg
// Description : Shared ML-KEM constants, share-pair type and mod-q
//               correction helpers for the masked NTT front end.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_defines_pkg;

  localparam int unsigned MLKEM_Q               = 3329;
  localparam int unsigned MLKEM_BARRETT24_M     = 20642678;
  localparam int unsigned MLKEM_BARRETT24_SHIFT = 36;
  localparam int unsigned MLKEM_N               = 256;
  localparam int unsigned MLKEM_SHARE_W         = 24;

  typedef logic [1:0][MLKEM_SHARE_W-1:0] share_pair_t;

  // Single conditional subtraction: maps [0, 2q) onto [0, q).
  function automatic logic [11:0] mlkem_csub_q(input logic [12:0] a);
    logic [12:0] t;
    t = (a >= 13'(MLKEM_Q)) ? (a - 13'(MLKEM_Q)) : a;
    return 12'(t);
  endfunction

  // Single conditional addition: maps a 13-bit two's-complement difference
  // in (-q, q) onto [0, q).
  function automatic logic [11:0] mlkem_cadd_q(input logic [12:0] d);
    logic [12:0] t;
    t = d[12] ? (d + 13'(MLKEM_Q)) : d;
    return 12'(t);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_mlkem_masked_share_gen_barrett.sv
`default_nettype none
// ============================================================================
// Module      : mlkem_barrett24_reduce
// Description : Combinational 24-bit Barrett reduction to [0, q), q = 3329.
//               The shifted-product quotient is at most one short, so one
//               conditional subtraction completes the reduction.
// Revision    : 1.0 - initial release
// ============================================================================
module mlkem_barrett24_reduce
  import ntt_defines_pkg::*;
(
  input  logic [23:0] i_a,
  output logic [11:0] o_r
);

  localparam logic [48:0] C_M = 49'(MLKEM_BARRETT24_M);

  logic [48:0] w_prod;
  logic [12:0] w_quot;
  logic [24:0] w_qq;
  logic [12:0] w_rem;

  // Quotient estimate, remainder in [0, 2q), then final correction.
  always_comb begin
    w_prod = 49'(i_a) * C_M;
    w_quot = 13'(w_prod >> MLKEM_BARRETT24_SHIFT);
    w_qq   = 25'(w_quot) * 25'(MLKEM_Q);
    w_rem  = 13'(25'(i_a) - w_qq);
    o_r    = mlkem_csub_q(w_rem);
  end

endmodule
`default_nettype wire

// File: rtl/ntt_mlkem_masked_share_gen.sv
`default_nettype none
// ============================================================================
// Module      : ntt_mlkem_masked_share_gen
// Description : Splits plain 12-bit coefficients into two arithmetic shares
//               mod q: share0 = (x - r) mod q, share1 = r. Two-stage
//               valid/ready pipeline, one coefficient per clock.
//               Optional recombination self-check: ABR_SHARE_GEN_SELFCHECK_EN
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_mlkem_masked_share_gen
  import ntt_defines_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int COEFF_W = 12,
  parameter int N_COEFF = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    zeroize,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COEFF_W-1:0]      in_coeff,
  input  logic [WIDTH-1:0]        rnd_24bit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0][WIDTH-1:0]   out_shares,
  output logic                    out_last,
  output logic                    selfcheck_err
);

  localparam int               CNT_W      = $clog2(N_COEFF);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N_COEFF - 1);

  logic             w_clr, w_s1_load, w_s2_load, w_in_fire, w_last;
  logic [11:0]      w_rnd_red;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [11:0]      s1_x_q, s1_x_d, s1_r_q, s1_r_d;
  logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [11:0]      s2_s0_q, s2_s0_d, s2_s1_q, s2_s1_d;

  mlkem_barrett24_reduce u_rnd_reduce (
    .i_a (24'(rnd_24bit)),
    .o_r (w_rnd_red)
  );

  // Pipeline advance, coefficient index and both share stages.
  always_comb begin
    w_clr      = reset | zeroize;
    w_s2_load  = !s2_valid_q || out_ready;
    w_s1_load  = !s1_valid_q || w_s2_load;
    w_in_fire  = in_valid && w_s1_load;
    w_last     = (cnt_q == C_CNT_LAST);

    cnt_d      = cnt_q;
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_r_d     = s1_r_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_s0_d    = s2_s0_q;
    s2_s1_d    = s2_s1_q;
    s2_last_d  = s2_last_q;

    if (w_in_fire) begin
      cnt_d = w_last ? '0 : cnt_q + 1'b1;
    end

    if (w_s1_load) begin
      s1_valid_d = w_in_fire;
      if (w_in_fire) begin
        s1_x_d    = mlkem_csub_q(13'(in_coeff));
        s1_r_d    = w_rnd_red;
        s1_last_d = w_last;
      end
    end

    if (w_s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_s0_d   = mlkem_cadd_q({1'b0, s1_x_q} - {1'b0, s1_r_q});
        s2_s1_d   = s1_r_q;
        s2_last_d = s1_last_q;
      end
    end
  end

  // State registers; reset and zeroize both flush everything.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_r_q     <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_s0_q    <= '0;
      s2_s1_q    <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_r_q     <= s1_r_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_s0_q    <= s2_s0_d;
      s2_s1_q    <= s2_s1_d;
      s2_last_q  <= s2_last_d;
    end
  end

  // Output drive: shares are < q, upper bits zero-extended.
  always_comb begin
    in_ready         = w_s1_load;
    out_valid        = s2_valid_q;
    out_last         = s2_last_q;
    out_shares       = '0;
    out_shares[0][11:0] = s2_s0_q;
    out_shares[1][11:0] = s2_s1_q;
  end

`ifdef ABR_SHARE_GEN_SELFCHECK_EN
  logic [11:0] s2_x_q, s2_x_d;
  logic        err_q, err_d;
  logic [11:0] w_recomb;

  // Shadow recombination of the departing pair against the carried x'.
  always_comb begin
    s2_x_d   = s2_x_q;
    if (w_s2_load && s1_valid_q) begin
      s2_x_d = s1_x_q;
    end
    w_recomb = mlkem_csub_q(13'(s2_s0_q) + 13'(s2_s1_q));
    err_d    = err_q | (s2_valid_q && out_ready && (w_recomb != s2_x_q));
  end

  // Shadow registers; the error flag is sticky until reset or zeroize.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      s2_x_q <= '0;
      err_q  <= 1'b0;
    end else begin
      s2_x_q <= s2_x_d;
      err_q  <= err_d;
    end
  end

  assign selfcheck_err = err_q;
`else
  assign selfcheck_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_mlkem_masked_share_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_mlkem_masked_share_gen
// Description : Directed + scoreboard bench for ntt_mlkem_masked_share_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_mlkem_masked_share_gen;

  localparam int Q = 3329;

  logic             clk = 1'b0;
  logic             reset, zeroize, in_valid, in_ready, out_valid, out_ready;
  logic [11:0]      in_coeff;
  logic [23:0]      rnd_24bit;
  logic [1:0][23:0] out_shares;
  logic             out_last, selfcheck_err;

  typedef struct { int x; int s0; int s1; bit last; } exp_t;
  exp_t sb_q[$];

  int n_checks = 0, n_pass = 0;
  int n_in = 0, n_out = 0, n_last = 0, mdl_cnt = 0;
  bit stall_prev = 0;
  logic [23:0] prev_s0, prev_s1;
  logic        prev_last;

  ntt_mlkem_masked_share_gen #(.WIDTH(24), .COEFF_W(12), .N_COEFF(256)) dut (
    .clk(clk), .reset(reset), .zeroize(zeroize),
    .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
    .rnd_24bit(rnd_24bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_shares(out_shares), .out_last(out_last), .selfcheck_err(selfcheck_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (reset || zeroize) begin
      sb_q.delete();
      mdl_cnt    = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {31'd0, out_valid}, 1);
        check("stall_s0", {8'd0, out_shares[0]}, {8'd0, prev_s0});
        check("stall_s1", {8'd0, out_shares[1]}, {8'd0, prev_s1});
        check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", {31'd0, sb_q.size() != 0}, 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_s0", {8'd0, out_shares[0]}, e.s0);
          check("sb_s1", {8'd0, out_shares[1]}, e.s1);
          check("sb_last", {31'd0, out_last}, {31'd0, e.last});
          check("sb_recomb", (int'(out_shares[0]) + int'(out_shares[1])) % Q, e.x);
        end
        n_out++;
        if (out_last) n_last++;
      end
      stall_prev = out_valid && !out_ready;
      prev_s0    = out_shares[0];
      prev_s1    = out_shares[1];
      prev_last  = out_last;
      if (in_valid && in_ready) begin
        exp_t e;
        e.x    = int'(in_coeff) % Q;
        e.s1   = int'(rnd_24bit) % Q;
        e.s0   = (e.x - e.s1 + Q) % Q;
        e.last = (mdl_cnt == 255);
        sb_q.push_back(e);
        mdl_cnt = (mdl_cnt == 255) ? 0 : mdl_cnt + 1;
        n_in++;
      end
    end
  end

  // Offer n coefficients with the given valid/ready percentages.
  task automatic send(input int n, input int p_valid, input int p_ready, output int cycles);
    int target;
    target = n_in + n;
    cycles = 0;
    while (n_in < target && cycles < 50000) begin
      in_valid  = ($urandom_range(99) < p_valid);
      out_ready = ($urandom_range(99) < p_ready);
      in_coeff  = 12'($urandom_range(4095));
      rnd_24bit = 24'($urandom);
      step();
      cycles++;
    end
    in_valid = 1'b0;
    check("send_count", n_in, target);
  endtask

  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && g < 50) begin
      step();
      g++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    int cyc, l0, a0;
    reset = 1'b1; zeroize = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_coeff = '0; rnd_24bit = '0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_s0", {8'd0, out_shares[0]}, 0);
    check("rst_s1", {8'd0, out_shares[1]}, 0);
    check("rst_last", {31'd0, out_last}, 0);
    check("rst_err", {31'd0, selfcheck_err}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);

    // Directed vectors, back to back.
    out_ready = 1'b1; in_valid = 1'b1; in_coeff = 12'd0; rnd_24bit = 24'd0;
    step();
    in_coeff = 12'd1; rnd_24bit = 24'd5;
    check("lat_not_yet", {31'd0, out_valid}, 0);
    step();
    in_coeff = 12'd4095; rnd_24bit = 24'hFFFFFF;
    check("d0_valid", {31'd0, out_valid}, 1);
    check("d0_s0", {8'd0, out_shares[0]}, 0);
    check("d0_s1", {8'd0, out_shares[1]}, 0);
    check("d0_last", {31'd0, out_last}, 0);
    step();
    in_valid = 1'b0;
    check("d1_s0", {8'd0, out_shares[0]}, 3325);
    check("d1_s1", {8'd0, out_shares[1]}, 5);
    step();
    check("d2_s0", {8'd0, out_shares[0]}, 1711);
    check("d2_s1", {8'd0, out_shares[1]}, 2384);
    check("d2_recomb", (int'(out_shares[0]) + int'(out_shares[1])) % Q, 766);
    drain();

    // Full polynomial plus one, at full rate.
    reset = 1'b1; step(); reset = 1'b0;
    l0 = n_last; a0 = n_out;
    send(257, 100, 100, cyc);
    check("stream_cycles", cyc, 257);
    drain();
    check("stream_outs", n_out - a0, 257);
    check("stream_last_cnt", n_last - l0, 1);

    // Stall from an empty pipeline: exactly two accepts, then backpressure.
    out_ready = 1'b0; in_valid = 1'b1; a0 = n_in;
    repeat (5) begin
      in_coeff = 12'($urandom_range(4095)); rnd_24bit = 24'($urandom);
      step();
    end
    check("stall_accepts", n_in - a0, 2);
    check("stall_in_ready", {31'd0, in_ready}, 0);
    in_valid = 1'b0;
    drain();

    // Zeroize with two items in flight at count 100.
    reset = 1'b1; step(); reset = 1'b0;
    send(100, 100, 100, cyc);
    out_ready = 1'b0; zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    check("zer_out_valid", {31'd0, out_valid}, 0);
    check("zer_s0", {8'd0, out_shares[0]}, 0);
    check("zer_s1", {8'd0, out_shares[1]}, 0);
    check("zer_last", {31'd0, out_last}, 0);
    l0 = n_last;
    send(256, 100, 100, cyc);
    drain();
    check("zer_last_cnt", n_last - l0, 1);

    // Random traffic with random backpressure.
    send(10000, 75, 75, cyc);
    drain();
    check("rand_err", {31'd0, selfcheck_err}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_mlkem_masked_share_gen.md
# ntt_mlkem_masked_share_gen

Front-end masking encoder for the ML-KEM masked NTT datapath. It accepts plain 12-bit polynomial coefficients on a valid/ready stream and splits each into two arithmetic shares mod q = 3329 using fresh randomness. The output pairs feed the masked butterfly/multiply pipeline, which needs two-share inputs. It is the producer for that share interface, and runs at a sustained throughput of one coefficient per clock.

## Interface
- WIDTH, 24: share width in bits; share values are < q and zero-extended to WIDTH
- COEFF_W, 12: plain coefficient width
- N_COEFF, 256: coefficients per polynomial, used for `out_last`
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  reset; synchronous, active-high
- zeroize  input  1  synchronous clear of all state and data registers, same effect as reset
- in_valid  input  1  coefficient valid
- in_ready  output  1  block can accept a coefficient
- in_coeff  input  COEFF_W  plain coefficient, any value 0..4095
- rnd_24bit  input  WIDTH  mask randomness, sampled only on an input handshake
- out_valid  output  1  share pair valid
- out_ready  input  1  downstream accepts the share pair
- out_shares  output  [1:0][WIDTH]  [0] = (x − r) mod q, [1] = r
- out_last  output  1  marks the N_COEFF-th coefficient of a polynomial
- selfcheck_err  output  1  sticky recombination mismatch flag

## Operation
- Input handshake fires when `in_valid && in_ready`.
- Stage 1, registered:
  - Coefficient reduction: x' = x − q if x ≥ q, else x (4095 < 2q, so one subtraction is enough).
  - Randomness reduction: r = rnd_24bit mod q by Barrett, with M = 20642678 and shift 36, followed by at most one conditional subtraction of q.
  - The last tag is captured here.
- Stage 2, registered:
  - Share 0: s0 = x' − r; add q if the difference is negative.
  - Share 1: s1 = r.
- Both shares are always in [0, q−1]. The upper WIDTH−12 bits are 0.
- Coefficient counter:
  - 8 bits for N_COEFF = 256; increments on each input handshake.
  - Tag is `last = (count == N_COEFF−1)`. The counter wraps to 0 after that coefficient.
  - The tag travels with the data through both stages.
- Reset or zeroize:
  - All valids, shares, `out_last`, the counter and `selfcheck_err` go to 0.
  - In-flight data is discarded; no partial polynomial state is kept.
  - If reset or zeroize is asserted mid-polynomial, the next accepted coefficient is index 0.

## Timing
- Latency: the input handshake in cycle t gives `out_valid` in cycle t+2 when nothing stalls.
- Throughput: one coefficient per cycle with `out_ready` held high.
- Pipeline advance:
  - Stage 2 loads when `!s2_valid || out_ready`.
  - Stage 1 loads when `!s1_valid || stage2_loads`.
  - `in_ready` = `!s1_valid || stage2_loads`. It is combinational from `out_ready`, and bubbles are collapsed.
- Stall: while `out_valid && !out_ready`, `out_shares` and `out_last` hold stable. `out_valid` never drops without a handshake.
- Simultaneous handshakes: input and output handshakes in the same cycle are legal, and the pipeline shifts without a bubble.
- Randomness use: `rnd_24bit` is don't-care in cycles with no input handshake. Each accepted coefficient uses exactly one sample.
- Reset values: `in_ready` = 1 (after reset deasserts), `out_valid` = 0, `out_shares` = 0, `out_last` = 0, `selfcheck_err` = 0.

## Configuration
- Macro: `ABR_SHARE_GEN_SELFCHECK_EN`.
- Defined:
  - A stage-3 shadow check computes (s0 + s1) mod q for each output handshake and compares it with the x' carried alongside.
  - A mismatch sets `selfcheck_err`, which stays set until reset or zeroize.
  - The check adds no latency to the output path.
- Undefined: `selfcheck_err` is tied to 0, no shadow logic is built, and the port list is unchanged.

## Structure
- Shared package `ntt_defines_pkg` holds:
  - `MLKEM_Q` = 3329
  - `MLKEM_BARRETT24_M` = 20642678
  - `MLKEM_BARRETT24_SHIFT` = 36
  - `MLKEM_N` = 256
  - A `share_pair_t` typedef for `[1:0][WIDTH-1:0]`
- One sub-module, `mlkem_barrett24_reduce`: a combinational 24-bit to mod-q reducer used in stage 1. The self-check reuses the q-add/subtract helper logic inline.

## Test plan
- After reset, `in_coeff`=0 and `rnd_24bit`=0 with `out_ready`=1 → two cycles later shares are (0, 0), `out_valid`=1, `out_last`=0.
- `in_coeff`=1 and `rnd_24bit`=5 → shares (3325, 5). Then `in_coeff`=4095 and `rnd_24bit`=0xFFFFFF → shares (1711, 2384), which recombine to 766.
- Stream 256 back-to-back coefficients with `out_ready`=1 → one output per cycle and `out_last` only on the 256th. A 257th coefficient has index 0.
- Hold `out_ready`=0 for 5 cycles mid-stream → `in_ready` drops after 2 accepts, outputs stay stable, and no coefficient is lost or duplicated (compare against a scoreboard).
- Assert reset or zeroize with 2 items in flight at count 100 → next cycle `out_valid`=0 and shares are 0. The next polynomial's `out_last` falls on its 256th coefficient.
- Random stimulus of 10k coefficients with random `out_ready` and `ABR_SHARE_GEN_SELFCHECK_EN` defined → every (s0 + s1) mod q equals x mod q, both shares are < q, and `selfcheck_err` stays 0.
